// File: rtl/dec_str_to_bin_pkg.sv
// Shared types and constants for the decimal-string to binary-code converter.
//   - state encoding for the control FSM
//   - ASCII digit bounds, datapath widths, default full-scale value
//   - result payload struct (code + error flag)
package dec_str_to_bin_pkg;

    localparam int unsigned STR_W          = 32;
    localparam int unsigned CHAR_W         = 8;
    localparam int unsigned N_CHARS        = 4;
    localparam int unsigned CNT_W          = 2;
    localparam int unsigned ACC_W          = 14;
    localparam int unsigned DVD_W          = 10;
    localparam int unsigned REM_W          = 11;
    localparam int unsigned Q_W            = 16;
    localparam int unsigned DIV_ITERS      = 16;
    localparam int unsigned ITER_W         = 4;
    localparam int unsigned FULL_SCALE_DEF = 1000;

    localparam logic [CHAR_W-1:0] ASCII_ZERO = 8'h30;
    localparam logic [CHAR_W-1:0] ASCII_NINE = 8'h39;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PARSE  = 3'd1,
        S_RANGE  = 3'd2,
        S_DIV    = 3'd3,
        S_FINISH = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    typedef struct packed {
        logic           err;
        logic [Q_W-1:0] code;
    } result_t;

    // True for characters '0'..'9'
    function automatic logic is_digit(input logic [CHAR_W-1:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/dec_str_to_bin_if.sv
// Request/result bundle between a text front end and the converter.
//   start : level request
//   din   : 4 ASCII chars, thousands char in the top byte
//   done  : ready / result valid
//   dout  : converted 16-bit code
//   err   : last conversion was invalid or out of range
interface dec_str_to_bin_if;
    import dec_str_to_bin_pkg::*;

    logic             start;
    logic [STR_W-1:0] din;
    logic             done;
    logic [Q_W-1:0]   dout;
    logic             err;

    modport master (output start, output din, input done, input dout, input err);
    modport slave  (input start, input din, output done, output dout, output err);

endinterface

// File: rtl/dec_str_to_bin_serial_restoring_div.sv
// Serial restoring divider: quot = floor(dividend * 2^16 / DIVISOR), one bit per step.
// The dividend must already be below DIVISOR so the remainder stays under 2*DIVISOR.
//   clk, rstn : clock, synchronous active-low reset
//   load      : capture dividend, clear quotient and iteration count
//   step      : perform one shift/subtract iteration
//   dividend  : 10-bit starting remainder
//   rem       : 11-bit running remainder
//   quot      : 16-bit quotient
//   busy      : iterations outstanding
//   last_c    : current step is the final iteration
module serial_restoring_div
    import dec_str_to_bin_pkg::*;
#(
    parameter int unsigned DIVISOR = FULL_SCALE_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             step,
    input  logic [DVD_W-1:0] dividend,
    output logic [REM_W-1:0] rem,
    output logic [Q_W-1:0]   quot,
    output logic             busy,
    output logic             last_c
);

    logic [ITER_W-1:0] iter;
    logic [REM_W-1:0]  rem_x2;
    logic              take;

    // Remainder is always below DIVISOR < 1024, so the top bit is zero before the shift
    assign rem_x2 = {rem[REM_W-2:0], 1'b0};
    assign take   = rem_x2 >= REM_W'(DIVISOR);
    assign last_c = busy && (iter == ITER_W'(DIV_ITERS - 1));

    // Iteration registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rem  <= '0;
            quot <= '0;
            iter <= '0;
            busy <= 1'b0;
        end else if (load) begin
            rem  <= REM_W'(dividend);
            quot <= '0;
            iter <= '0;
            busy <= 1'b1;
        end else if (step && busy) begin
            rem  <= take ? (rem_x2 - REM_W'(DIVISOR)) : rem_x2;
            quot <= {quot[Q_W-2:0], take};
            iter <= iter + ITER_W'(1);
            if (last_c) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dec_str_to_bin.sv
// ASCII decimal string "0000".."FULL_SCALE" to 16-bit full-scale code.
// dout = floor(N * 65536 / FULL_SCALE), optional round half-up, saturating at 0xFFFF.
//   clk  : system clock
//   rstn : synchronous active-low reset, aborts any conversion
//   bus  : slave side of dec_str_to_bin_if (start/din in, done/dout/err out)
module dec_str_to_bin
    import dec_str_to_bin_pkg::*;
#(
    parameter int unsigned FULL_SCALE = FULL_SCALE_DEF,
    parameter int unsigned ROUND      = 0
) (
    input  logic               clk,
    input  logic               rstn,
    dec_str_to_bin_if.slave    bus
);

    state_t            state, state_nxt;
    logic [STR_W-1:0]  sreg, sreg_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic              bad, bad_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    result_t           res, res_nxt;
    logic              done_q, done_nxt;

    logic              div_load, div_step;
    logic [REM_W-1:0]  div_rem;
    logic [Q_W-1:0]    div_quot;
    logic              div_busy, div_last_c;

    logic [CHAR_W-1:0] ch;
    logic [CHAR_W-1:0] digit;
    logic              acc_ge, acc_gt;
    logic              round_up;

    assign ch     = sreg[STR_W-1 -: CHAR_W];
    assign digit  = ch - ASCII_ZERO;
    assign acc_ge = acc >= ACC_W'(FULL_SCALE);
    assign acc_gt = acc >  ACC_W'(FULL_SCALE);

    // Round half-up on the final remainder, never past full scale
    assign round_up = (ROUND == 1)
                   && ({div_rem, 1'b0} >= (REM_W + 1)'(FULL_SCALE))
                   && (div_quot != '1);

    serial_restoring_div #(
        .DIVISOR (FULL_SCALE)
    ) u_div (
        .clk      (clk),
        .rstn     (rstn),
        .load     (div_load),
        .step     (div_step),
        .dividend (DVD_W'(acc)),
        .rem      (div_rem),
        .quot     (div_quot),
        .busy     (div_busy),
        .last_c   (div_last_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_PARSE;
            S_PARSE:  if (cnt == CNT_W'(N_CHARS - 1)) state_nxt = S_RANGE;
            S_RANGE:  state_nxt = (bad || acc_ge) ? S_DONE : S_DIV;
            S_DIV:    if (div_last_c) state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_DONE;
            S_DONE:   if (!bus.start) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        sreg_nxt = sreg;
        acc_nxt  = acc;
        bad_nxt  = bad;
        cnt_nxt  = cnt;
        res_nxt  = res;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    sreg_nxt = bus.din;
                    acc_nxt  = '0;
                    bad_nxt  = 1'b0;
                    cnt_nxt  = '0;
                end
            end
            S_PARSE: begin
                if (!is_digit(ch)) begin
                    bad_nxt = 1'b1;
                end
                // acc is wide enough for "9999"; contents are don't-care once bad is set
                acc_nxt  = ACC_W'(acc * ACC_W'(10)) + ACC_W'(digit);
                sreg_nxt = {sreg[STR_W-CHAR_W-1:0], CHAR_W'(0)};
                cnt_nxt  = cnt + CNT_W'(1);
            end
            S_RANGE: begin
                if (bad) begin
                    res_nxt.code = '0;
                    res_nxt.err  = 1'b1;
                end else if (acc_ge) begin
                    res_nxt.code = '1;
                    res_nxt.err  = acc_gt;
                end else begin
                    div_load = 1'b1;
                end
            end
            S_DIV: begin
                div_step = div_busy;
            end
            S_FINISH: begin
                res_nxt.code = div_quot + Q_W'(round_up);
                res_nxt.err  = 1'b0;
            end
            default: ;
        endcase
    end

    assign done_nxt = (state_nxt == S_IDLE) || (state_nxt == S_DONE);

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sreg   <= '0;
            acc    <= '0;
            bad    <= 1'b0;
            cnt    <= '0;
            res    <= '0;
            done_q <= 1'b1;
        end else begin
            sreg   <= sreg_nxt;
            acc    <= acc_nxt;
            bad    <= bad_nxt;
            cnt    <= cnt_nxt;
            res    <= res_nxt;
            done_q <= done_nxt;
        end
    end

    assign bus.done = done_q;
    assign bus.dout = res.code;
    assign bus.err  = res.err;

endmodule

// File: tb/tb_dec_str_to_bin.sv
// Self-checking bench: truncating and rounding instances driven in lockstep,
// compared against an arithmetic reference model.
module tb_dec_str_to_bin;

    localparam int FS = 1000;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [31:0] din;

    int n_checks;
    int n_errors;

    dec_str_to_bin_if bus0 ();
    dec_str_to_bin_if bus1 ();

    assign bus0.start = start;
    assign bus0.din   = din;
    assign bus1.start = start;
    assign bus1.din   = din;

    dec_str_to_bin #(.FULL_SCALE(FS), .ROUND(0)) u_dut_trunc (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus0)
    );

    dec_str_to_bin #(.FULL_SCALE(FS), .ROUND(1)) u_dut_round (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: decimal value of the string, then scaled by 65536/FS
    task automatic ref_model(input logic [31:0] s, input bit rnd,
                             output logic [15:0] d, output logic e, output int lat);
        int          n;
        bit          bad;
        logic [7:0]  c;
        longint      num, q, r;
        n   = 0;
        bad = 0;
        for (int k = 3; k >= 0; k--) begin
            c = s[k*8 +: 8];
            if (c < 8'h30 || c > 8'h39) bad = 1;
            else n = n * 10 + int'(c) - 48;
        end
        if (bad) begin
            d = 16'h0000; e = 1'b1; lat = 5;
        end else if (n >= FS) begin
            d = 16'hFFFF; e = (n > FS); lat = 5;
        end else begin
            num = longint'(n) * 65536;
            q   = num / FS;
            r   = num % FS;
            if (rnd && (2 * r >= FS) && (q != 65535)) q = q + 1;
            d = 16'(q); e = 1'b0; lat = 22;
        end
    endtask

    task automatic run_conv(input logic [31:0] s, input int hold, input bit toggle);
        logic [15:0] ed0, ed1, pd0, pd1;
        logic        ee0, ee1, pe0, pe1;
        int          elat, lat;
        bit          stable_ok, held_ok;
        ref_model(s, 1'b0, ed0, ee0, elat);
        ref_model(s, 1'b1, ed1, ee1, elat);
        pd0 = bus0.dout; pe0 = bus0.err;
        pd1 = bus1.dout; pe1 = bus1.err;
        stable_ok = 1;
        @(negedge clk);
        din   = s;
        start = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            din = $urandom;
            if (!(bus0.done && bus1.done)) begin
                if (bus0.done || bus1.done) stable_ok = 0;
                if (bus0.dout !== pd0 || bus0.err !== pe0 ||
                    bus1.dout !== pd1 || bus1.err !== pe1) stable_ok = 0;
                if (toggle) start = 1'($urandom_range(0, 1));
            end
        end while (!(bus0.done && bus1.done) && lat < 40);
        start = 1'b1;
        check($sformatf("latency \"%s\"", s), 32'(lat), 32'(elat));
        check($sformatf("busy_stable \"%s\"", s), 32'(stable_ok), 32'd1);
        check($sformatf("dout_trunc \"%s\"", s), 32'(bus0.dout), 32'(ed0));
        check($sformatf("err_trunc \"%s\"", s), 32'(bus0.err), 32'(ee0));
        check($sformatf("dout_round \"%s\"", s), 32'(bus1.dout), 32'(ed1));
        check($sformatf("err_round \"%s\"", s), 32'(bus1.err), 32'(ee1));
        held_ok = 1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            if (!bus0.done || !bus1.done || bus0.dout !== ed0 || bus1.dout !== ed1) held_ok = 0;
        end
        check($sformatf("no_retrigger \"%s\"", s), 32'(held_ok), 32'd1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_str();
        logic [31:0] s;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 15) == 0)
                s[k*8 +: 8] = 8'($urandom);
            else if (k == 3)
                s[k*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'h31 : 8'h30;
            else
                s[k*8 +: 8] = 8'(8'h30 + $urandom_range(0, 9));
        end
        return s;
    endfunction

    initial begin
        logic [31:0] dir_list [10];
        n_checks = 0;
        n_errors = 0;
        rstn  = 1'b0;
        start = 1'b0;
        din   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_done", 32'(bus0.done), 32'd1);
        check("reset_dout", 32'(bus0.dout), 32'd0);
        check("reset_err",  32'(bus0.err),  32'd0);
        @(negedge clk);
        rstn = 1'b1;

        run_conv("0500", 5, 0);
        dir_list = '{"0001", "0999", "0000", "1000", "1001",
                     "9999", "12A4", " 500", "0250", "0750"};
        foreach (dir_list[i]) run_conv(dir_list[i], 1, 0);

        // Abort in the middle of the divide
        @(negedge clk);
        din   = "0500";
        start = 1'b1;
        @(posedge clk);
        repeat (13) @(posedge clk);
        #1;
        check("busy_before_abort", 32'(bus0.done), 32'd0);
        @(negedge clk);
        rstn  = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_done", 32'(bus0.done), 32'd1);
        check("abort_dout", 32'(bus0.dout), 32'd0);
        check("abort_err",  32'(bus1.err),  32'd0);
        @(negedge clk);
        rstn = 1'b1;

        run_conv("0500", 2, 1);
        for (int t = 0; t < 40; t++) run_conv(rand_str(), 1, (t % 3) == 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
